// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_pkg;
  localparam int WIDTH_DEF = 1;
  localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/fa_bit_cell.sv
// One-bit combinational full adder built from gate primitives.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p, g, t;

  xor u_p  (p, a, b);
  xor u_s  (s, p, ci);
  and u_g  (g, a, b);
  and u_t  (t, p, ci);
  or  u_co (co, g, t);
endmodule

// File: rtl/full_adder_seq.sv
// Registered WIDTH-bit ripple-carry adder with a valid strobe.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module full_adder_seq
  import full_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In_0,
  input  logic [WIDTH-1:0] In_1,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sout,
  output logic             Cout,
`ifdef FULL_ADDER_OVF_EN
  output logic             Ovf,
`endif
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit_cell u_cell (
      .a  (In_0[i]),
      .b  (In_1[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Result registers only load on valid operands; out_valid is a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sout      <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sout <= sum;
        Cout <= c[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n)        Ovf <= 1'b0;
    else if (in_valid) Ovf <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif
endmodule

// File: tb/tb_full_adder_seq.sv
// Randomized self-checking bench for full_adder_seq (WIDTH=1 and WIDTH=8 instances)
// against an arithmetic reference model; Ovf is checked when FULL_ADDER_OVF_EN is defined.
module tb_full_adder_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, cin, vin;
  logic [7:0] a8, b8;
  logic       s1, c1, v1, o1;
  logic [7:0] s8;
  logic       c8, v8, o8;

  int vec_cnt = 0;
  int err_cnt = 0;

  // model state
  logic       m_en = 1'b0;
  logic       m1_s, m1_c, m1_v, m1_o;
  logic [7:0] m8_s;
  logic       m8_c, m8_v, m8_o;

  always #50 clk = ~clk;

  full_adder_seq #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .In_0(a1), .In_1(b1), .Cin(cin), .in_valid(vin),
    .Sout(s1), .Cout(c1),
`ifdef FULL_ADDER_OVF_EN
    .Ovf(o1),
`endif
    .out_valid(v1)
  );

  full_adder_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .In_0(a8), .In_1(b8), .Cin(cin), .in_valid(vin),
    .Sout(s8), .Cout(c8),
`ifdef FULL_ADDER_OVF_EN
    .Ovf(o8),
`endif
    .out_valid(v8)
  );

`ifndef FULL_ADDER_OVF_EN
  assign o1 = 1'b0;
  assign o8 = 1'b0;
`endif

  function automatic logic sovf(longint sa, longint sb, longint ci, int w);
    longint s = sa + sb + ci;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    return (s > hi) || (s < lo);
  endfunction

  // Reference: plain integer addition, hold on invalid, clear on reset.
  always @(posedge clk) begin
    longint t1, t8;
    if (!rst_n) begin
      m_en = 1'b1;
      m1_s = 0; m1_c = 0; m1_v = 0; m1_o = 0;
      m8_s = 0; m8_c = 0; m8_v = 0; m8_o = 0;
    end else begin
      m1_v = vin;
      m8_v = vin;
      if (vin) begin
        t1 = longint'(a1) + longint'(b1) + longint'(cin);
        t8 = longint'(a8) + longint'(b8) + longint'(cin);
        m1_s = t1[0];   m1_c = t1[1];
        m8_s = t8[7:0]; m8_c = t8[8];
        m1_o = sovf(a1 ? -1 : 0, b1 ? -1 : 0, longint'(cin), 1);
        m8_o = sovf(longint'($signed(a8)), longint'($signed(b8)), longint'(cin), 8);
      end
    end
  end

  task automatic chk(string name, longint act, longint exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_en) begin
      chk("w1_sout", s1, m1_s);
      chk("w1_cout", c1, m1_c);
      chk("w1_valid", v1, m1_v);
      chk("w8_sout", s8, m8_s);
      chk("w8_cout", c8, m8_c);
      chk("w8_valid", v8, m8_v);
`ifdef FULL_ADDER_OVF_EN
      chk("w1_ovf", o1, m1_o);
      chk("w8_ovf", o8, m8_o);
`endif
    end
  end

  // Drive at the negedge, let the next posedge sample, return at the following negedge.
  task automatic step(logic r, logic x1, logic y1, logic [7:0] x8, logic [7:0] y8,
                      logic ci, logic v);
    rst_n = r; a1 = x1; b1 = y1; a8 = x8; b8 = y8; cin = ci; vin = v;
    @(negedge clk);
  endtask

  logic [2:0] exp1 [8];
  int stream_cnt;

  initial begin
    exp1 = '{3'b000, 3'b010, 3'b010, 3'b101, 3'b010, 3'b101, 3'b101, 3'b111};

    // reset with live operands, two edges
    rst_n = 0; a1 = 1; b1 = 1; a8 = 8'hFF; b8 = 8'hFF; cin = 1; vin = 1;
    @(negedge clk);
    step(0, 1, 1, 8'hFF, 8'hFF, 1, 1);
    chk("rst_sout", s1, 0);
    chk("rst_cout", c1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_sout8", s8, 0);
    step(1, 1, 1, 8'hFF, 8'hFF, 1, 1);
    chk("post_rst_sout", s1, 1);
    chk("post_rst_cout", c1, 1);
    chk("post_rst_valid", v1, 1);
    chk("w8_ones_sout", s8, 8'hFF);
    chk("w8_ones_cout", c8, 1);

    // exhaustive WIDTH=1
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      step(1, abc[2], abc[1], 8'h00, 8'h00, abc[0], 1);
      chk("exh_sout", s1, exp1[i][1]);
      chk("exh_cout", c1, exp1[i][0]);
      chk("exh_valid", v1, exp1[i][2] | 1'b1);
    end

    // hold
    step(1, 1, 1, 8'h00, 8'h00, 0, 1);
    chk("hold_pre_sout", s1, 0);
    chk("hold_pre_cout", c1, 1);
    step(1, 0, 0, 8'h00, 8'h00, 1, 0);
    chk("hold_sout", s1, 0);
    chk("hold_cout", c1, 1);
    chk("hold_valid", v1, 0);

    // WIDTH=8 ripple and overflow corners
    step(1, 0, 0, 8'hFF, 8'h00, 1, 1);
    chk("rip_sout", s8, 8'h00);
    chk("rip_cout", c8, 1);
    step(1, 0, 0, 8'hFF, 8'hFF, 1, 1);
    chk("rip2_sout", s8, 8'hFF);
    chk("rip2_cout", c8, 1);
    step(1, 0, 0, 8'h7F, 8'h01, 0, 1);
    chk("ovf1_sout", s8, 8'h80);
    chk("ovf1_cout", c8, 0);
`ifdef FULL_ADDER_OVF_EN
    chk("ovf1_ovf", o8, 1);
`endif
    step(1, 0, 0, 8'h80, 8'hFF, 0, 1);
    chk("ovf2_sout", s8, 8'h7F);
    chk("ovf2_cout", c8, 1);
`ifdef FULL_ADDER_OVF_EN
    chk("ovf2_ovf", o8, 1);
`endif
    step(1, 0, 0, 8'h01, 8'h01, 0, 1);
    chk("ovf3_sout", s8, 8'h02);
`ifdef FULL_ADDER_OVF_EN
    chk("ovf3_ovf", o8, 0);
`endif

    // streaming: 8 back-to-back valid operands
    stream_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1);
      stream_cnt += int'(v8);
    end
    chk("stream_count", stream_cnt, 8);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0);
    chk("stream_end_valid", v8, 0);

    // random traffic with sparse resets and gaps
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), 8'($urandom),
           8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/full_adder_seq.md
FULL_ADDER_SEQ -- requirements
Module: full_adder_seq

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 In_0  input  WIDTH  addend A, unsigned (two's complement when overflow feature enabled).
REQ-005 In_1  input  WIDTH  addend B, same encoding as In_0.
REQ-006 Cin  input  1  carry into bit 0.
REQ-007 in_valid  input  1  operands on In_0/In_1/Cin are valid this cycle.
REQ-008 Sout  output  WIDTH  registered sum bits.
REQ-009 Cout  output  1  registered carry out of bit WIDTH-1.
REQ-010 out_valid  output  1  Sout/Cout hold a new result this cycle.
REQ-011 Ovf  output  1  registered signed overflow; present only when FULL_ADDER_OVF_EN is defined.

Function
REQ-012 Sum per bit i: s[i] = In_0[i] XOR In_1[i] XOR c[i]; c[0] = Cin.
REQ-013 Carry per bit i: c[i+1] = (In_0[i] AND In_1[i]) OR (c[i] AND (In_0[i] XOR In_1[i])); Cout = c[WIDTH].
REQ-014 {Cout, Sout} equals In_0 + In_1 + Cin exactly, WIDTH+1 bits, no truncation.
REQ-015 Latency: operands sampled at edge N with in_valid=1 appear on Sout/Cout at edge N, visible for cycle N+1; out_valid=1 for exactly that cycle.
REQ-016 in_valid=0 at an edge: Sout/Cout/Ovf hold previous values, out_valid=0 next cycle.
REQ-017 Back-to-back in_valid=1: one result per cycle, no bubbles, no backpressure.
REQ-018 Carry chain is a pure ripple; no state other than the output registers and out_valid.
REQ-019 All-ones plus all-ones plus Cin=1: Sout = all-ones, Cout = 1.

Reset
REQ-020 rst_n=0 at a rising edge: Sout=0, Cout=0, out_valid=0, Ovf=0 (if present), regardless of in_valid.
REQ-021 Reset has priority over in_valid; an operand presented with rst_n=0 is discarded, no result produced.
REQ-022 First in_valid=1 edge after rst_n returns high produces a result one cycle later per REQ-015.

Configuration
REQ-023 Macro FULL_ADDER_OVF_EN defined: Ovf port exists; Ovf registered with Sout, = c[WIDTH] XOR c[WIDTH-1] (for WIDTH=1, c[0]=Cin).
REQ-024 Macro undefined: no Ovf port, no overflow logic; all other behaviour identical.

Structure
REQ-025 Shared package full_adder_pkg holds WIDTH default constant and max-width constant (64).
REQ-026 One sub-module fa_bit_cell: combinational one-bit full adder (a, b, ci -> s, co) built from XOR/AND/OR gate primitives; instantiated WIDTH times in a generate loop.
REQ-027 Top-level contains only the generate chain, output registers, valid register and optional overflow logic.

Verification
REQ-028 WIDTH=1 exhaustive: all 8 combinations of In_0/In_1/Cin with in_valid=1, 100 ns apart -> (0,0,0)->S0 C0; (0,0,1)->S1 C0; (0,1,0)->S1 C0; (0,1,1)->S0 C1; (1,0,0)->S1 C0; (1,0,1)->S0 C1; (1,1,0)->S0 C1; (1,1,1)->S1 C1, each one cycle after sampling.
REQ-029 Reset: drive In_0=1, In_1=1, Cin=1, in_valid=1, rst_n=0 for 2 edges -> Sout=0, Cout=0, out_valid=0; release rst_n -> next cycle Sout=1, Cout=1, out_valid=1.
REQ-030 Hold: result 1+1+0 (S0 C1), then in_valid=0 with inputs 0,0,1 -> Sout=0, Cout=1 retained, out_valid=0.
REQ-031 WIDTH=8 full ripple: In_0=8'hFF, In_1=8'h00, Cin=1 -> Sout=8'h00, Cout=1; 8'hFF+8'hFF+1 -> Sout=8'hFF, Cout=1.
REQ-032 WIDTH=8 with FULL_ADDER_OVF_EN: 8'h7F+8'h01+0 -> Sout=8'h80, Cout=0, Ovf=1; 8'h80+8'hFF+0 -> Sout=8'h7F, Cout=1, Ovf=1; 8'h01+8'h01+0 -> Ovf=0.
REQ-033 Streaming: 8 consecutive valid operand sets -> 8 consecutive out_valid=1 cycles, results in order, each matching In_0+In_1+Cin.
